// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port, a pending-write
// scoreboard and a post-reset clear sweep. Optional write-to-read forwarding: REGFILE_SB_BYPASS_EN.
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ready,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    input  logic            WE3,
    input  logic [AW-1:0]   A3,
    input  logic [XLEN-1:0] WD3,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd,
    output logic            busy1,
    output logic            busy2,
    output logic            stall
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   w_cnt_next;
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_next;
    logic [XLEN-1:0] r_regs [NREG];

    logic            w_run;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_addr;
    logic [XLEN-1:0] w_mem_data;

    assign w_run = (r_state == RUN);
    assign ready = w_run;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_cnt   <= AW'(1);
            r_busy  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_busy  <= w_busy_next;
        end
    end

    // The sweep and writeback share the single write port of the storage array.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_mem_we     = 1'b0;
        w_mem_addr   = A3;
        w_mem_data   = WD3;
        case (r_state)
            CLEAR: begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_cnt;
                w_mem_data = '0;
                w_cnt_next = r_cnt + AW'(1);
                if (r_cnt == AW'(NREG - 1)) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_mem_we = WE3 && (A3 != '0);
            end
            default: begin
                w_state_next = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) begin
            r_regs[w_mem_addr] <= w_mem_data;
        end
    end

    // A same-cycle issue outranks the writeback release: the new producer owns the register.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign w_busy_next[gi] = 1'b0;
            end else begin : g_reg
                assign w_busy_next[gi] =
                    (w_run && issue_en && (issue_rd == AW'(gi))) ? 1'b1 :
                    (w_run && WE3      && (A3       == AW'(gi))) ? 1'b0 :
                    r_busy[gi];
            end
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic [AW-1:0]   w_addr;
            logic [XLEN-1:0] w_data;
            logic            w_bz;

            assign w_addr = (gi == 0) ? A1 : A2;

            always_comb begin
                w_data = '0;
                w_bz   = 1'b0;
                if (w_run && (w_addr != '0)) begin
                    w_data = r_regs[w_addr];
                    w_bz   = r_busy[w_addr];
`ifdef REGFILE_SB_BYPASS_EN
                    if (WE3 && (A3 == w_addr)) begin
                        w_data = WD3;
                        w_bz   = w_busy_next[w_addr];
                    end
`endif
                end
            end
        end
    endgenerate

    assign RD1   = g_rd[0].w_data;
    assign RD2   = g_rd[1].w_data;
    assign busy1 = g_rd[0].w_bz;
    assign busy2 = g_rd[1].w_bz;
    assign stall = busy1 | busy2;

endmodule
